// File: rtl/csi2_pkg.sv
// Shared definitions for the CSI-2 RAW10 depacketizer: data types, parser states and
// header field helpers.
package csi2_pkg;

    localparam logic [5:0] DT_FS       = 6'h00;
    localparam logic [5:0] DT_FE       = 6'h01;
    localparam logic [5:0] DT_LS       = 6'h02;
    localparam logic [5:0] DT_LE       = 6'h03;
    localparam logic [7:0] DT_RAW10    = 8'h2B;
    // Data types below this value are short packets (no payload, no CRC).
    localparam logic [5:0] DT_LONG_MIN = 6'h10;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        PAYLOAD,
        CRC,
        SKIP
    } state_e;

    function automatic logic [1:0] di_vc(input logic [7:0] di);
        return di[7:6];
    endfunction

    function automatic logic [5:0] di_dt(input logic [7:0] di);
        return di[5:0];
    endfunction

    function automatic logic wc_legal(input logic [15:0] wc, input logic [15:0] max_wc);
        return (wc != 16'd0) && (wc <= max_wc) && ((wc % 16'd5) == 16'd0);
    endfunction

endpackage

// File: rtl/raw10_unpack.sv
// Assembles 5-byte RAW10 groups and emits the four 10-bit pixels on the following four
// cycles from a holding register, independent of gaps in the incoming byte stream.
module raw10_unpack (
    input  logic       clk,
    input  logic       rst,
    input  logic       byte_en,
    input  logic [7:0] byte_data,
    input  logic       byte_last,
    input  logic       clear,
    output logic       pix_valid,
    output logic [9:0] pix_data,
    output logic       pix_last
);

    logic [2:0]      idx_q;
    logic [3:0][7:0] msb_q;
    logic [39:0]     hold_q;
    logic [2:0]      cnt_q;
    logic            last_q;
    logic            load;

    assign load = byte_en && !clear && (idx_q == 3'd4);

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q  <= 3'd0;
            msb_q  <= '0;
            hold_q <= '0;
            cnt_q  <= 3'd0;
            last_q <= 1'b0;
        end else begin
            if (clear) begin
                idx_q <= 3'd0;
            end else if (byte_en) begin
                if (idx_q == 3'd4) begin
                    idx_q <= 3'd0;
                end else begin
                    msb_q[idx_q[1:0]] <= byte_data;
                    idx_q             <= idx_q + 3'd1;
                end
            end

            // A new group needs five bytes, so it can never land while four pixels are
            // still draining; loading simply takes priority.
            if (load) begin
                hold_q <= {msb_q[3], byte_data[7:6], msb_q[2], byte_data[5:4],
                           msb_q[1], byte_data[3:2], msb_q[0], byte_data[1:0]};
                cnt_q  <= 3'd4;
                last_q <= byte_last;
            end else if (cnt_q != 3'd0) begin
                hold_q <= hold_q >> 10;
                cnt_q  <= cnt_q - 3'd1;
            end
        end
    end

    assign pix_valid = (cnt_q != 3'd0);
    assign pix_data  = hold_q[9:0];
    assign pix_last  = last_q && (cnt_q == 3'd1);

endmodule

// File: rtl/csi2_raw10_depacketizer.sv
// CSI-2 packet parser: decodes short and long packet headers from the merged byte stream,
// filters on VC/DT, hands RAW10 payload to the unpacker and keeps frame/error counters.
module csi2_raw10_depacketizer #(
    parameter logic [7:0]  DT_RAW10 = csi2_pkg::DT_RAW10,
    parameter logic [15:0] MAX_WC   = 16'd4000,
    parameter int unsigned LCNT_W   = 12
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              enable,
    input  logic [1:0]        vc_sel,
    input  logic              byte_valid,
    input  logic              byte_sot,
    input  logic [7:0]        byte_data,
    output logic              pix_valid,
    output logic [9:0]        pix_data,
    output logic              pix_last,
    output logic              fs_pulse,
    output logic              fe_pulse,
    output logic              ls_pulse,
    output logic              le_pulse,
    output logic              frame_active,
    output logic [LCNT_W-1:0] line_cnt,
    output logic              err_wc,
    output logic              err_trunc,
    output logic [7:0]        err_count
);

    import csi2_pkg::state_e;
    import csi2_pkg::IDLE;
    import csi2_pkg::HDR;
    import csi2_pkg::PAYLOAD;
    import csi2_pkg::CRC;
    import csi2_pkg::SKIP;
    import csi2_pkg::DT_FS;
    import csi2_pkg::DT_FE;
    import csi2_pkg::DT_LS;
    import csi2_pkg::DT_LE;
    import csi2_pkg::DT_LONG_MIN;
    import csi2_pkg::di_vc;
    import csi2_pkg::di_dt;
    import csi2_pkg::wc_legal;

    state_e      state_q, state_d;
    logic [7:0]  di_q, di_d;
    logic [7:0]  wc_lo_q, wc_lo_d;
    logic [7:0]  wc_hi_q, wc_hi_d;
    logic [1:0]  hdr_cnt_q, hdr_cnt_d;
    logic [16:0] remaining_q, remaining_d;
    logic        fs_d, fe_d, ls_d, le_d;
    logic        err_wc_d, err_trunc_d, line_inc;
    logic        grp_byte, grp_last, grp_clear;
    logic [15:0] wc;
    logic        vc_match;
    logic [5:0]  dt;
    logic [8:0]  err_sum;

    assign wc       = {wc_hi_q, wc_lo_q};
    assign vc_match = (di_vc(di_q) == vc_sel);
    assign dt       = di_dt(di_q);

    always_comb begin
        state_d     = state_q;
        di_d        = di_q;
        wc_lo_d     = wc_lo_q;
        wc_hi_d     = wc_hi_q;
        hdr_cnt_d   = hdr_cnt_q;
        remaining_d = remaining_q;
        fs_d        = 1'b0;
        fe_d        = 1'b0;
        ls_d        = 1'b0;
        le_d        = 1'b0;
        err_wc_d    = 1'b0;
        err_trunc_d = 1'b0;
        line_inc    = 1'b0;
        grp_byte    = 1'b0;
        grp_last    = 1'b0;
        grp_clear   = 1'b0;

        if (!enable) begin
            state_d = IDLE;
        end else if (byte_valid) begin
            if (byte_sot) begin
                // Any SOT restarts parsing; mid-packet it also abandons the partial group.
                err_trunc_d = (state_q != IDLE);
                grp_clear   = 1'b1;
                di_d        = byte_data;
                hdr_cnt_d   = 2'd0;
                state_d     = HDR;
            end else begin
                case (state_q)
                    HDR: begin
                        hdr_cnt_d = hdr_cnt_q + 2'd1;
                        if (hdr_cnt_q == 2'd0) begin
                            wc_lo_d = byte_data;
                        end else if (hdr_cnt_q == 2'd1) begin
                            wc_hi_d = byte_data;
                        end else begin
                            state_d = IDLE;
                            if (dt < DT_LONG_MIN) begin
                                if (vc_match) begin
                                    fs_d = (dt == DT_FS);
                                    fe_d = (dt == DT_FE);
                                    ls_d = (dt == DT_LS);
                                    le_d = (dt == DT_LE);
                                end
                            end else if (!wc_legal(wc, MAX_WC)) begin
                                err_wc_d    = 1'b1;
                                state_d     = SKIP;
                                remaining_d = {1'b0, wc} + 17'd2;
                            end else if (vc_match && (dt == DT_RAW10[5:0])) begin
                                state_d     = PAYLOAD;
                                remaining_d = {1'b0, wc};
                            end else begin
                                state_d     = SKIP;
                                remaining_d = {1'b0, wc} + 17'd2;
                            end
                        end
                    end
                    PAYLOAD: begin
                        grp_byte    = 1'b1;
                        grp_last    = (remaining_q == 17'd1);
                        remaining_d = remaining_q - 17'd1;
                        if (remaining_q == 17'd1) begin
                            state_d     = CRC;
                            remaining_d = 17'd2;
                        end
                    end
                    CRC: begin
                        line_inc    = (remaining_q == 17'd2);
                        remaining_d = remaining_q - 17'd1;
                        if (remaining_q == 17'd1) begin
                            state_d = IDLE;
                        end
                    end
                    SKIP: begin
                        remaining_d = remaining_q - 17'd1;
                        if (remaining_q == 17'd1) begin
                            state_d = IDLE;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    assign err_sum = {1'b0, err_count} + {8'd0, err_wc_d} + {8'd0, err_trunc_d};

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q      <= IDLE;
            di_q         <= 8'd0;
            wc_lo_q      <= 8'd0;
            wc_hi_q      <= 8'd0;
            hdr_cnt_q    <= 2'd0;
            remaining_q  <= 17'd0;
            fs_pulse     <= 1'b0;
            fe_pulse     <= 1'b0;
            ls_pulse     <= 1'b0;
            le_pulse     <= 1'b0;
            err_wc       <= 1'b0;
            err_trunc    <= 1'b0;
            frame_active <= 1'b0;
            line_cnt     <= '0;
            err_count    <= 8'd0;
        end else begin
            state_q     <= state_d;
            di_q        <= di_d;
            wc_lo_q     <= wc_lo_d;
            wc_hi_q     <= wc_hi_d;
            hdr_cnt_q   <= hdr_cnt_d;
            remaining_q <= remaining_d;
            fs_pulse    <= fs_d;
            fe_pulse    <= fe_d;
            ls_pulse    <= ls_d;
            le_pulse    <= le_d;
            err_wc      <= err_wc_d;
            err_trunc   <= err_trunc_d;

            if (fs_d) begin
                frame_active <= 1'b1;
            end else if (fe_d) begin
                frame_active <= 1'b0;
            end

            if (fs_d) begin
                line_cnt <= '0;
            end else if (line_inc && (line_cnt != {LCNT_W{1'b1}})) begin
                line_cnt <= line_cnt + {{(LCNT_W-1){1'b0}}, 1'b1};
            end

            err_count <= (err_sum > 9'd255) ? 8'hFF : err_sum[7:0];
        end
    end

    raw10_unpack u_unpack (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .byte_en   (grp_byte),
        .byte_data (byte_data),
        .byte_last (grp_last),
        .clear     (grp_clear),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .pix_last  (pix_last)
    );

endmodule

// File: tb/tb_csi2_raw10_depacketizer.sv
// Scoreboard bench for csi2_raw10_depacketizer: stimulus queues expected pixels and
// strobes, a negedge monitor pops and compares whatever the DUT presents.
module tb_csi2_raw10_depacketizer;

    localparam int LCNT_W = 12;

    localparam logic [2:0] K_PIX   = 3'd0;
    localparam logic [2:0] K_FS    = 3'd1;
    localparam logic [2:0] K_FE    = 3'd2;
    localparam logic [2:0] K_LS    = 3'd3;
    localparam logic [2:0] K_LE    = 3'd4;
    localparam logic [2:0] K_ERRWC = 3'd5;
    localparam logic [2:0] K_TRUNC = 3'd6;

    typedef struct packed {
        logic [2:0] kind;
        logic [9:0] data;
        logic       last;
        logic       consec;
    } ev_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic [1:0]        vc_sel;
    logic              byte_valid;
    logic              byte_sot;
    logic [7:0]        byte_data;
    logic              pix_valid;
    logic [9:0]        pix_data;
    logic              pix_last;
    logic              fs_pulse, fe_pulse, ls_pulse, le_pulse;
    logic              frame_active;
    logic [LCNT_W-1:0] line_cnt;
    logic              err_wc, err_trunc;
    logic [7:0]        err_count;

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  last_pix_cyc = -10;
    ev_t exp_q[$];

    always #5 clk = ~clk;

    csi2_raw10_depacketizer #(
        .DT_RAW10 (8'h2B),
        .MAX_WC   (16'd4000),
        .LCNT_W   (LCNT_W)
    ) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .enable       (enable),
        .vc_sel       (vc_sel),
        .byte_valid   (byte_valid),
        .byte_sot     (byte_sot),
        .byte_data    (byte_data),
        .pix_valid    (pix_valid),
        .pix_data     (pix_data),
        .pix_last     (pix_last),
        .fs_pulse     (fs_pulse),
        .fe_pulse     (fe_pulse),
        .ls_pulse     (ls_pulse),
        .le_pulse     (le_pulse),
        .frame_active (frame_active),
        .line_cnt     (line_cnt),
        .err_wc       (err_wc),
        .err_trunc    (err_trunc),
        .err_count    (err_count)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic got(input logic [2:0] k, input logic [9:0] d, input logic l);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event kind=%0d data=%h last=%0d (nothing expected)",
                     k, d, l);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || (k == K_PIX && (e.data != d || e.last != l))) begin
                errors++;
                $display("FAIL event got kind=%0d data=%h last=%0d want kind=%0d data=%h last=%0d",
                         k, d, l, e.kind, e.data, e.last);
            end
            if (k == K_PIX && e.consec) begin
                checks++;
                if (cyc != last_pix_cyc + 1) begin
                    errors++;
                    $display("FAIL pixel_spacing got gap=%0d want 1", cyc - last_pix_cyc);
                end
            end
        end
        if (k == K_PIX) last_pix_cyc = cyc;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (pix_valid) got(K_PIX, pix_data, pix_last);
            if (fs_pulse)  got(K_FS, 10'd0, 1'b0);
            if (fe_pulse)  got(K_FE, 10'd0, 1'b0);
            if (ls_pulse)  got(K_LS, 10'd0, 1'b0);
            if (le_pulse)  got(K_LE, 10'd0, 1'b0);
            if (err_wc)    got(K_ERRWC, 10'd0, 1'b0);
            if (err_trunc) got(K_TRUNC, 10'd0, 1'b0);
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, want);
        end
    endtask

    task automatic exp_ev(input logic [2:0] k);
        exp_q.push_back('{kind: k, data: 10'd0, last: 1'b0, consec: 1'b0});
    endtask

    task automatic exp_pix(input logic [9:0] d, input logic l, input logic c);
        exp_q.push_back('{kind: K_PIX, data: d, last: l, consec: c});
    endtask

    task automatic send(input logic [7:0] b, input logic sot);
        byte_valid = 1'b1;
        byte_sot   = sot;
        byte_data  = b;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        byte_sot   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Bytes are taken MSB-first from the right-aligned concatenation.
    task automatic send_seq(input logic [127:0] bytes, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            send(bytes[8*(n-1-i) +: 8], 1'b0);
            if (gap > 0) idle(gap);
        end
    endtask

    task automatic send_hdr(input logic [7:0] di, input logic [15:0] wc);
        send(di, 1'b1);
        send(wc[7:0], 1'b0);
        send(wc[15:8], 1'b0);
        send(8'h00, 1'b0);
    endtask

    task automatic chk_zero();
        chk("rst_pix_valid", {15'd0, pix_valid}, 16'd0);
        chk("rst_pix_data", {6'd0, pix_data}, 16'd0);
        chk("rst_pulses", {10'd0, fs_pulse, fe_pulse, ls_pulse, le_pulse, err_wc, err_trunc},
            16'd0);
        chk("rst_frame_active", {15'd0, frame_active}, 16'd0);
        chk("rst_line_cnt", {4'd0, line_cnt}, 16'd0);
        chk("rst_err_count", {8'd0, err_count}, 16'd0);
    endtask

    task automatic line_aa();
        exp_pix(10'h2A8, 1'b0, 1'b0);
        exp_pix(10'h2ED, 1'b0, 1'b1);
        exp_pix(10'h332, 1'b0, 1'b1);
        exp_pix(10'h377, 1'b1, 1'b1);
        send_hdr(8'h2B, 16'd5);
        send_seq({8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hE4, 8'h5A, 8'hA5}, 7, 0);
    endtask

    initial begin
        rst        = 1'b1;
        enable     = 1'b1;
        vc_sel     = 2'd0;
        byte_valid = 1'b0;
        byte_sot   = 1'b0;
        byte_data  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // Frame and line sync short packets
        exp_ev(K_FS);
        send_hdr(8'h00, 16'd0);
        idle(3);
        chk("fs_frame_active", {15'd0, frame_active}, 16'd1);
        exp_ev(K_LS);
        send_hdr(8'h02, 16'd0);
        exp_ev(K_LE);
        send_hdr(8'h03, 16'd0);
        exp_ev(K_FE);
        send_hdr(8'h01, 16'd0);
        idle(3);
        chk("fe_frame_active", {15'd0, frame_active}, 16'd0);
        chk("fe_line_cnt", {4'd0, line_cnt}, 16'd0);

        // One RAW10 line inside a frame
        exp_ev(K_FS);
        send_hdr(8'h00, 16'd0);
        line_aa();
        idle(6);
        chk("raw10_line_cnt", {4'd0, line_cnt}, 16'd1);

        // Gapped WC=10 line
        exp_pix(10'h047, 1'b0, 1'b0);
        exp_pix(10'h08A, 1'b0, 1'b1);
        exp_pix(10'h0CD, 1'b0, 1'b1);
        exp_pix(10'h110, 1'b0, 1'b1);
        exp_pix(10'h3FF, 1'b0, 1'b0);
        exp_pix(10'h000, 1'b0, 1'b1);
        exp_pix(10'h201, 1'b0, 1'b1);
        exp_pix(10'h1FE, 1'b1, 1'b1);
        send_hdr(8'h2B, 16'd10);
        send_seq({8'h11, 8'h22, 8'h33, 8'h44, 8'h1B, 8'hFF, 8'h00, 8'h80, 8'h7F, 8'h93,
                  8'h12, 8'h34}, 12, 1);
        idle(6);
        chk("gapped_line_cnt", {4'd0, line_cnt}, 16'd2);

        // Filtered packets: wrong VC, then wrong DT
        send_hdr(8'h6B, 16'd5);
        send_seq({8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07}, 7, 0);
        send_hdr(8'h2C, 16'd5);
        send_seq({8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07}, 7, 0);
        idle(4);
        chk("filter_line_cnt", {4'd0, line_cnt}, 16'd2);
        exp_ev(K_FS);
        send_hdr(8'h00, 16'd0);
        idle(3);
        chk("refs_line_cnt", {4'd0, line_cnt}, 16'd0);
        chk("refs_frame_active", {15'd0, frame_active}, 16'd1);

        // Illegal WC skips WC+2 bytes; next packet parses normally
        exp_ev(K_ERRWC);
        send_hdr(8'h2B, 16'd7);
        send_seq({8'h2B, 8'h2B, 8'h2B, 8'h2B, 8'h2B, 8'h2B, 8'h2B, 8'h2B, 8'h2B}, 9, 0);
        idle(3);
        chk("errwc_count", {8'd0, err_count}, 16'd1);
        line_aa();
        idle(6);
        chk("after_errwc_line_cnt", {4'd0, line_cnt}, 16'd1);

        // Truncation at payload byte 2, FS takes over
        exp_ev(K_TRUNC);
        exp_ev(K_FS);
        send_hdr(8'h2B, 16'd5);
        send_seq({8'hAA, 8'hBB}, 2, 0);
        send_hdr(8'h00, 16'd0);
        idle(3);
        chk("trunc_err_count", {8'd0, err_count}, 16'd2);
        chk("trunc_line_cnt", {4'd0, line_cnt}, 16'd0);
        line_aa();
        idle(6);
        chk("after_trunc_line_cnt", {4'd0, line_cnt}, 16'd1);

        // Reset mid-line; the tail of that line must then be ignored
        send_hdr(8'h2B, 16'd5);
        send_seq({8'hAA, 8'hBB, 8'hCC}, 3, 0);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        @(negedge clk);
        chk_zero();
        @(posedge clk);
        #1;
        send_seq({8'hDD, 8'hE4, 8'h5A, 8'hA5}, 4, 0);
        idle(6);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) idle(1);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending events want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
